ll_sc_monitor: RTL

- Reservation controller that sequences the LL/SC link bit for the single-issue core.
- Records the address reserved by LL and judges each SC as success or failure.
- Cancels the reservation on exception flush, external snoop writes to the reserved granule, or timeout.
- Sits beside the MEM stage; drives the link bit seen by the write-back path and the SC result consumed in MEM.

---
 rtl/ll_sc_pkg.sv | 11 +
 rtl/ll_sc_timer.sv | 18 +
 rtl/ll_sc_monitor.sv | 55 +++++
 3 files changed

// File: rtl/ll_sc_pkg.sv
// ll_sc_pkg: shared state encoding, default parameters and granule match for the LL/SC monitor
package ll_sc_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RESERVED = 1'b1} state_t;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_GRAN_LSB = 2;
  localparam int DEF_TIMEOUT  = 1023;
  localparam int DEF_CNT_W    = 10;
  function automatic logic gran_match(input logic [63:0] a, input logic [63:0] b, input int lsb);
    return (a >> lsb) == (b >> lsb);
  endfunction
endpackage

// File: rtl/ll_sc_timer.sv
// ll_sc_timer: reservation age counter with synchronous clear and expiry flag
module ll_sc_timer #(
  parameter int TIMEOUT = ll_sc_pkg::DEF_TIMEOUT,
  parameter int CNT_W   = ll_sc_pkg::DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt;
  assign expire = (TIMEOUT != 0) & en & (cnt == CNT_W'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/ll_sc_monitor.sv
// ll_sc_monitor: LL/SC reservation tracker judging SC success beside the MEM stage
module ll_sc_monitor
  import ll_sc_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int GRAN_LSB = DEF_GRAN_LSB,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ll_valid,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_valid,
  input  logic [ADDR_W-1:0] sc_addr,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              sc_success_o,
  output logic              llbit_o,
  output logic [ADDR_W-1:0] resv_addr_o,
  output logic [15:0]       sc_fail_cnt_o
);
  localparam logic [ADDR_W-1:0] GMASK = ~((ADDR_W'(1) << GRAN_LSB) - ADDR_W'(1));
  state_t state, state_nxt;
  logic [ADDR_W-1:0] resv_addr;
  logic snoop_hit, expire, ll_take, resv;
  assign resv         = state == ST_RESERVED;
  assign snoop_hit    = snoop_valid & resv & gran_match(64'(snoop_addr), 64'(resv_addr), GRAN_LSB);
  assign sc_success_o = !rst & sc_valid & resv & gran_match(64'(sc_addr), 64'(resv_addr), GRAN_LSB)
                        & !snoop_hit & !flush;
  assign ll_take      = ll_valid & !flush;
  assign state_nxt    = flush ? ST_IDLE : ll_valid ? ST_RESERVED
                      : (sc_valid | snoop_hit | expire) ? ST_IDLE : state;
  assign llbit_o      = resv;
  assign resv_addr_o  = resv_addr;
  ll_sc_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (ll_take | (state_nxt != ST_RESERVED)),
    .en    (resv),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      resv_addr     <= '0;
      sc_fail_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (ll_take) resv_addr <= ll_addr & GMASK;
      if (sc_valid && !sc_success_o && !(&sc_fail_cnt_o)) sc_fail_cnt_o <= sc_fail_cnt_o + 1'b1;
    end
  end
endmodule
